// File: rtl/hazard_unit.sv
// ID-stage stall and branch-compare forwarding generator, driven by a 3-deep shadow of in-flight writers.
// Optional perf counters (stall_cnt, flush_cnt) are built when HAZARD_PERF_EN is defined.
module hazard_unit #(
  parameter int unsigned RF_AW    = 5,
  parameter int unsigned LINK_REG = 31,
  parameter int unsigned CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] IF_ID_instr,
  input  logic        EX_MEM_branch_tacken,
  output logic        stall,
  output logic [3:0]  forwardSignal
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2b
  } op_e;

  typedef struct packed {
    logic             wr;
    logic             load;
    logic [RF_AW-1:0] dst;
  } shadow_t;

  shadow_t ex, mem, wb;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [RF_AW-1:0] rs, rt, rd;
  logic             d_wr, d_load, use_rs, use_rt, is_beq;
  logic [RF_AW-1:0] d_dst;
  shadow_t          dec;
  logic             unused_shamt;

  assign op           = IF_ID_instr[31:26];
  assign funct        = IF_ID_instr[5:0];
  assign rs           = RF_AW'(IF_ID_instr[25:21]);
  assign rt           = RF_AW'(IF_ID_instr[20:16]);
  assign rd           = RF_AW'(IF_ID_instr[15:11]);
  assign unused_shamt = ^IF_ID_instr[10:6];

  always_comb begin
    d_wr   = 1'b0;
    d_load = 1'b0;
    d_dst  = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    is_beq = 1'b0;
    if (IF_ID_instr != '0) begin
      case (op) inside
        OP_RTYPE: begin
          d_dst  = rd;
          d_wr   = (funct != 6'h08);
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_LW: begin
          d_dst  = rt;
          d_wr   = 1'b1;
          d_load = 1'b1;
          use_rs = 1'b1;
        end
        OP_SW: begin
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        OP_BEQ: begin
          is_beq = 1'b1;
          use_rs = 1'b1;
          use_rt = 1'b1;
        end
        [6'h08:6'h0f]: begin
          d_dst  = rt;
          d_wr   = 1'b1;
          use_rs = 1'b1;
        end
        OP_JAL: begin
          d_dst = RF_AW'(LINK_REG);
          d_wr  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // r0 is never a real destination, so it must never produce a hit
  assign dec = '{wr: d_wr & (d_dst != '0), load: d_load, dst: d_dst};

  function automatic logic hit(shadow_t s, logic [RF_AW-1:0] x);
    return s.wr && (s.dst == x);
  endfunction

  function automatic logic [1:0] fsel(logic used, logic [RF_AW-1:0] x, shadow_t m, shadow_t w);
    if (!used)                 return 2'b00;
    if (hit(m, x) && !m.load)  return 2'b01;
    if (hit(w, x))             return 2'b10;
    return 2'b00;
  endfunction

  logic load_use, branch_dep;

  always_comb begin
    load_use   = ((use_rs && hit(ex, rs)) || (use_rt && hit(ex, rt))) && ex.load;
    branch_dep = is_beq && (
                   (use_rs && (hit(ex, rs) || (hit(mem, rs) && mem.load))) ||
                   (use_rt && (hit(ex, rt) || (hit(mem, rt) && mem.load))));
    stall      = !rst && !EX_MEM_branch_tacken && (load_use || branch_dep);
    forwardSignal = rst ? '0 : {fsel(use_rs, rs, mem, wb), fsel(use_rt, rt, mem, wb)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex  <= '0;
      mem <= '0;
      wb  <= '0;
    end else begin
      wb  <= mem;
      mem <= ex;
      ex  <= (stall || EX_MEM_branch_tacken) ? '0 : dec;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (EX_MEM_branch_tacken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end
`else
  // counters are not built in this configuration
`endif

endmodule
